// File: rtl/flash_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flash_pkg                                                                |
// | Shared SPI NOR flash command codes, address width and streamer states.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package flash_pkg;

    localparam logic [7:0] FREAD = 8'h0B;
    localparam logic [7:0] READ  = 8'h03;
    localparam logic [7:0] PP    = 8'h02;
    localparam logic [7:0] WREN  = 8'h06;
    localparam logic [7:0] RSTEN = 8'h66;
    localparam logic [7:0] RST   = 8'h99;

    localparam int FLASH_ADDR_W = 22;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_FINISH = 3'd4
    } stream_state_t;

    // Flash addresses wrap at the top of the device.
    function automatic logic [FLASH_ADDR_W-1:0] addr_inc(input logic [FLASH_ADDR_W-1:0] a);
        return a + FLASH_ADDR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flash_byte_fifo                                                          |
// | Synchronous byte FIFO with first-word-fall-through output and free count.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flash_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full = (r_count == C_DEPTH);
    assign w_push = push & ~w_full;
    assign w_pop  = pop & (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    assign out_data  = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    assign free      = C_DEPTH - r_count;

endmodule
`default_nettype wire

// File: rtl/flash_read_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flash_read_streamer                                                      |
// | Issues FREAD transactions, buffers bytes, pauses/resumes on backpressure.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flash_read_streamer
    import flash_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16,
    parameter int CS_GAP     = 3
) (
    input  logic                    interfaceClk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [FLASH_ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]        req_len,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    interfaceEnable_n,
    output logic [7:0]              fCommand,
    output logic [FLASH_ADDR_W-1:0] fAddress,
    input  logic [7:0]              fData_RD,
    input  logic                    RdDataValid
);
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W  = $clog2(CS_GAP + 1) + 1;
    localparam logic [FREE_W-1:0] C_PAUSE_FREE  = FREE_W'(2);
    localparam logic [FREE_W-1:0] C_RESUME_FREE = FREE_W'(FIFO_DEPTH / 2);
    localparam logic [GAP_W-1:0]  C_GAP         = GAP_W'(CS_GAP);
    localparam logic [GAP_W-1:0]  C_GAP_M1      = GAP_W'(CS_GAP - 1);
    localparam logic [LEN_W-1:0]  C_LEN_ONE     = LEN_W'(1);

    stream_state_t           r_state;
    logic [FLASH_ADDR_W-1:0] r_next_addr;
    logic [FLASH_ADDR_W-1:0] r_faddr;
    logic [LEN_W-1:0]        r_remaining;
    logic [GAP_W-1:0]        r_gap;
    logic                    r_rdv_q;
    logic                    r_cap_pend;
    logic                    r_req_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_en_n;

    logic                    w_rise;
    logic                    w_capture;
    logic                    w_last_capture;
    logic                    w_pop;
    logic [FREE_W-1:0]       w_free;

    // fData_RD lags the RdDataValid rise by one cycle, hence the pending stage.
    assign w_rise         = RdDataValid & ~r_rdv_q;
    assign w_capture      = r_cap_pend & (r_remaining != '0);
    assign w_last_capture = w_capture & (r_remaining == C_LEN_ONE);
    assign w_pop          = out_valid & out_ready;

    flash_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (interfaceClk),
        .rst       (reset),
        .push      (w_capture),
        .push_data (fData_RD),
        .pop       (w_pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .free      (w_free)
    );

    always_ff @(posedge interfaceClk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_next_addr <= '0;
            r_faddr     <= '0;
            r_remaining <= '0;
            r_gap       <= '0;
            r_rdv_q     <= 1'b0;
            r_cap_pend  <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_en_n      <= 1'b1;
        end else begin
            r_rdv_q    <= RdDataValid;
            r_cap_pend <= w_rise & (r_state == ST_STREAM);
            r_done     <= 1'b0;
            if (w_capture) begin
                r_next_addr <= addr_inc(r_next_addr);
                r_remaining <= r_remaining - C_LEN_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_next_addr <= req_addr;
                        r_remaining <= req_len;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (req_len == '0) begin
                            // The accept cycle already counts as one gap cycle.
                            r_state <= ST_FINISH;
                            r_gap   <= GAP_W'(1);
                            r_done  <= (CS_GAP == 1);
                        end else begin
                            r_state <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    r_faddr <= r_next_addr;
                    r_en_n  <= 1'b0;
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_last_capture) begin
                        r_en_n  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= ST_FINISH;
                    end else if (w_free <= C_PAUSE_FREE) begin
                        r_en_n  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_last_capture) begin
                        r_gap   <= '0;
                        r_state <= ST_FINISH;
                    end else if (r_gap < C_GAP) begin
                        r_gap <= r_gap + GAP_W'(1);
                    end else if (w_free >= C_RESUME_FREE) begin
                        r_state <= ST_START;
                    end
                end
                ST_FINISH: begin
                    r_gap  <= r_gap + GAP_W'(1);
                    r_done <= (r_gap == C_GAP_M1);
                    if (r_gap == C_GAP) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready         = r_req_ready;
    assign busy              = r_busy;
    assign done              = r_done;
    assign interfaceEnable_n = r_en_n;
    assign fAddress          = r_faddr;
    assign fCommand          = FREAD;

endmodule
`default_nettype wire

// File: tb/tb_flash_read_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flash_read_streamer                                                   |
// | Scoreboard bench with a behavioural flash model for flash_read_streamer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_flash_read_streamer;
    localparam int GAP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [21:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy, done, interfaceEnable_n;
    logic [7:0]  fCommand;
    logic [21:0] fAddress;
    logic [7:0]  fData_RD = '0;
    logic        RdDataValid = 1'b0;

    flash_read_streamer #(.FIFO_DEPTH(8), .LEN_W(16), .CS_GAP(GAP)) dut (
        .interfaceClk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .interfaceEnable_n(interfaceEnable_n),
        .fCommand(fCommand), .fAddress(fAddress), .fData_RD(fData_RD), .RdDataValid(RdDataValid)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, bytes_rx = 0, done_cnt = 0, acc_cnt = 0, win_cnt = 0, rise_cnt = 0;
    int done_cyc = 0, acc_cyc = 0, rise_cyc = 0;
    int rdy_mode = 0;
    logic [7:0]  exp_q[$];
    logic [21:0] fa_q[$];
    logic        prev_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Flash content is a fixed function of the address.
    function automatic logic [7:0] fbyte(input logic [21:0] a);
        return a[7:0] ^ a[21:14];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Flash interface model: latches fAddress when enable falls, then one byte every 8-12 cycles.
    bit          fm_active = 0, fm_pend = 0;
    int          fm_wait = 0, fm_hi = 0;
    logic [21:0] fm_addr = '0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (fm_pend) begin
                fData_RD = fbyte(fm_addr);
                fm_addr  = fm_addr + 22'd1;
                fm_pend  = 0;
            end
            if (reset || interfaceEnable_n) begin
                fm_active = 0; RdDataValid = 1'b0; fm_hi = 0;
            end else if (!fm_active) begin
                fm_active = 1; fm_addr = fAddress; fm_wait = $urandom_range(6, 12);
            end else begin
                if (fm_hi > 0) begin
                    fm_hi--;
                    if (fm_hi == 0) RdDataValid = 1'b0;
                end
                if (fm_wait > 0) fm_wait--;
                else begin
                    RdDataValid = 1'b1; fm_pend = 1;
                    fm_hi = $urandom_range(1, 3); fm_wait = $urandom_range(7, 11);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: scoreboard pops on every accepted output byte, plus event bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid && out_ready) begin
                    bytes_rx++;
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL stray_byte: got %02h, required no byte", out_data);
                    end else check("stream_byte", out_data, exp_q.pop_front());
                end
                if (done) begin
                    done_cnt++; done_cyc = cyc;
                    check("busy_at_done", busy, 1);
                end
                if (req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
                if (prev_en && !interfaceEnable_n) begin win_cnt++; fa_q.push_back(fAddress); end
                if (!prev_en && interfaceEnable_n) begin rise_cnt++; rise_cyc = cyc; end
                if (dut.u_fifo.push && dut.u_fifo.w_full) begin
                    n_tests++; n_fail++;
                    $display("FAIL fifo_overflow: push while full at cycle %0d, required no push", cyc);
                end
            end
            prev_en = interfaceEnable_n;
        end
    end

    task automatic issue(input logic [21:0] a, input int l);
        int  t = 0;
        bit  ok = 0;
        for (int i = 0; i < l; i++) exp_q.push_back(fbyte(a + 22'(i)));
        req_addr = a; req_len = 16'(l); req_valid = 1'b1;
        do begin
            @(negedge clk); ok = req_ready;
            @(posedge clk); t++;
        end while (!ok && t < 500);
        #1 req_valid = 1'b0;
        check("req_accepted", ok, 1);
    endtask

    task automatic wait_done_drain(input int d0, input int budget, input string nm);
        int t = 0;
        while (done_cnt == d0 && t < budget) begin @(posedge clk); t++; end
        check({nm, "_done_seen"}, done_cnt != d0, 1);
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin @(posedge clk); t++; end
        check({nm, "_drained"}, exp_q.size(), 0);
        #1;
    endtask

    task automatic wait_pause(input int r0, input string nm);
        int t = 0;
        while (rise_cnt == r0 && t < 2000) begin @(posedge clk); t++; end
        check({nm, "_paused"}, rise_cnt != r0, 1);
        #1;
    endtask

    initial begin
        int d0, w0, r0, f0, a0, b0, l;
        logic [21:0] a;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_enable_n", interfaceEnable_n, 1);
        check("rst_fcommand", fCommand, 8'h0B);
        check("rst_faddress", fAddress, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;

        // Basic read
        rdy_mode = 0; d0 = done_cnt; w0 = win_cnt; f0 = fa_q.size();
        issue(22'h000100, 4);
        wait_done_drain(d0, 2000, "basic");
        check("basic_done_pulses", done_cnt - d0, 1);
        check("basic_windows", win_cnt - w0, 1);
        check("basic_done_latency", done_cyc - rise_cyc, GAP);
        if (fa_q.size() > f0) check("basic_faddr", fa_q[f0], 22'h000100);

        // Backpressure: consumer stalled until the streamer pauses
        rdy_mode = 1; a = 22'h0ABC10; d0 = done_cnt; w0 = win_cnt; r0 = rise_cnt; f0 = fa_q.size();
        issue(a, 20);
        wait_pause(r0, "bp");
        repeat (10) @(posedge clk);
        #1 check("bp_stalled_valid", out_valid, 1);
        rdy_mode = 0;
        wait_done_drain(d0, 4000, "bp");
        check("bp_restarted", (win_cnt - w0) >= 2, 1);
        if (fa_q.size() > f0 + 1)
            check("bp_restart_offset", ((fa_q[f0 + 1] - a) == 22'd6) || ((fa_q[f0 + 1] - a) == 22'd7), 1);

        // Wrap-around, plain and with a forced pause right at the wrap point
        d0 = done_cnt;
        issue(22'h3FFFFE, 4);
        wait_done_drain(d0, 2000, "wrap");
        rdy_mode = 1; d0 = done_cnt; r0 = rise_cnt; f0 = fa_q.size();
        issue(22'h3FFFFA, 10);
        wait_pause(r0, "wrap_pause");
        rdy_mode = 0;
        wait_done_drain(d0, 4000, "wrap_pause");
        check("wrap_windows", fa_q.size() - f0 >= 2, 1);
        if (fa_q.size() > f0 + 1) begin
            check("wrap_first_faddr", fa_q[f0], 22'h3FFFFA);
            check("wrap_restart_faddr", fa_q[f0 + 1], 22'h000000);
        end

        // Zero length
        d0 = done_cnt; w0 = win_cnt;
        issue(22'h012345, 0);
        wait_done_drain(d0, 200, "zero");
        check("zero_windows", win_cnt - w0, 0);
        check("zero_done_latency", done_cyc - acc_cyc, GAP);

        // Reset mid-stream after 3 of 10 bytes
        rdy_mode = 0; b0 = bytes_rx; d0 = done_cnt;
        issue(22'h020000, 10);
        l = 0;
        while (bytes_rx - b0 < 3 && l < 2000) begin @(posedge clk); l++; end
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_enable_n", interfaceEnable_n, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        repeat (30) @(posedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        #1 d0 = done_cnt;
        issue(22'h020000, 10);
        wait_done_drain(d0, 3000, "after_rst");

        // Request held valid while busy
        a0 = acc_cnt; d0 = done_cnt;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 5; i++) exp_q.push_back(fbyte(22'h030000 + 22'(i)));
        req_addr = 22'h030000; req_len = 16'd5; req_valid = 1'b1;
        l = 0;
        while (acc_cnt - a0 < 2 && l < 3000) begin @(posedge clk); l++; end
        #1 req_valid = 1'b0;
        check("busy_accepts", acc_cnt - a0, 2);
        check("busy_accept_after_done", acc_cyc - done_cyc, 1);
        wait_done_drain(d0 + 1, 3000, "busy_second");

        // Randomized requests with random consumer backpressure
        rdy_mode = 2;
        for (int n = 0; n < 12; n++) begin
            l = $urandom_range(0, 24);
            a = ($urandom_range(0, 3) == 0) ? 22'h3FFFF0 + 22'($urandom_range(0, 15)) : 22'($urandom);
            d0 = done_cnt;
            issue(a, l);
            wait_done_drain(d0, 4000, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
